// File: rtl/dram_arbiter.sv
// Purpose: arbitrates an instruction and a data requester onto one DRAM port, one transaction in flight.
// Latency: capture at valid edge N, grant at N+1, dram_in valid in cycle N+2, response 1 cycle after dram_out.mem_ready.
// Backpressure: one capture slot per port; a valid seen while that port is pending is dropped.
// Build option: define DRAM_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed D-over-I priority.

package dram_arbiter_pkg;

   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_ready;
   } mem_out_type;

endpackage

module dram_arbiter
   import dram_arbiter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  dram_in,
   input  mem_out_type dram_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // grant_d=1 means the data port owns the current (or most recent) transaction
   logic        grant_d;
   logic        grant_d_nxt;

   logic        i_pend;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [3:0]  i_wstrb;

   logic        d_pend;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;

   logic        done;
   logic        i_done;
   logic        d_done;

   // DRAM completion only counts while a transaction is actually outstanding
   assign done   = (state == WAIT) && dram_out.mem_ready;
   assign i_done = done && !grant_d;
   assign d_done = done &&  grant_d;

   // State and grant registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         grant_d <= 1'b1;
      end else begin
         state   <= state_nxt;
         grant_d <= grant_d_nxt;
      end
   end

   // Next-state and grant selection; the grant only moves when leaving IDLE
   always_comb begin
      state_nxt   = state;
      grant_d_nxt = grant_d;
      case (state)
         IDLE: begin
            if (i_pend || d_pend) begin
               state_nxt = ISSUE;
               if (i_pend && d_pend) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                  grant_d_nxt = !grant_d;
`else
                  grant_d_nxt = 1'b1;
`endif
               end else begin
                  grant_d_nxt = d_pend;
               end
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (dram_out.mem_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Instruction capture slot: completion clears pending; a valid only loads an empty slot
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         i_pend  <= 1'b0;
         i_addr  <= '0;
         i_wdata <= '0;
         i_wstrb <= '0;
      end else begin
         if (i_done) begin
            i_pend <= 1'b0;
         end
         if (imem_in.mem_valid && !i_pend) begin
            i_pend  <= 1'b1;
            i_addr  <= imem_in.mem_addr;
            i_wdata <= imem_in.mem_wdata;
            i_wstrb <= imem_in.mem_wstrb;
         end
      end
   end

   // Data capture slot, same behaviour as the instruction slot
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         d_pend  <= 1'b0;
         d_addr  <= '0;
         d_wdata <= '0;
         d_wstrb <= '0;
      end else begin
         if (d_done) begin
            d_pend <= 1'b0;
         end
         if (dmem_in.mem_valid && !d_pend) begin
            d_pend  <= 1'b1;
            d_addr  <= dmem_in.mem_addr;
            d_wdata <= dmem_in.mem_wdata;
            d_wstrb <= dmem_in.mem_wstrb;
         end
      end
   end

   // DRAM request register: one-cycle valid pulse out of ISSUE, payload holds afterwards
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dram_in <= '0;
      end else if (state == ISSUE) begin
         dram_in.mem_valid <= 1'b1;
         dram_in.mem_addr  <= grant_d ? d_addr  : i_addr;
         dram_in.mem_wdata <= grant_d ? d_wdata : i_wdata;
         dram_in.mem_wstrb <= grant_d ? d_wstrb : i_wstrb;
      end else begin
         dram_in.mem_valid <= 1'b0;
      end
   end

   // Response routing: only the granted port sees a one-cycle ready with data, the other stays zero
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         imem_out <= '0;
         dmem_out <= '0;
      end else begin
         imem_out.mem_ready <= i_done;
         imem_out.mem_rdata <= i_done ? dram_out.mem_rdata : 32'h0;
         dmem_out.mem_ready <= d_done;
         dmem_out.mem_rdata <= d_done ? dram_out.mem_rdata : 32'h0;
      end
   end

endmodule
